// File: rtl/ecc_fifo_pkg.sv
// Shared constants, types and codeword helpers for the SECDED FIFO reader.
// Codeword layout: cw[12:1] = Hamming positions 1..12, cw[0] = overall even parity.
package ecc_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int CW_W   = 13;
    localparam int ADDR_W = 4;

    // Hamming position of each data bit d[0..7]; parity bits sit at 1, 2, 4, 8.
    localparam logic [ADDR_W-1:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sec;
        logic              ded;
    } rd_entry_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = cw[DATA_POS[i]];
        return d;
    endfunction

endpackage

// File: rtl/secded_dec_8.sv
// Combinational SECDED decoder for an 8-bit payload in a 13-bit extended
// Hamming codeword; shared by any reader that uses the ecc_fifo_pkg layout.
module secded_dec_8
    import ecc_fifo_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic              sec,
    output logic              ded
);

    logic [ADDR_W-1:0] syn;
    logic              par;
    logic [CW_W-1:0]   fixed;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) syn = syn ^ ADDR_W'(i);
        end
        par   = ^cw;
        fixed = cw;
        sec   = 1'b0;
        ded   = 1'b0;
        if (syn == '0) begin
            // Zero syndrome with odd parity means only cw[0] flipped.
            sec = par;
        end else if (par && (syn < ADDR_W'(CW_W))) begin
            fixed[syn] = ~cw[syn];
            sec        = 1'b1;
        end else begin
            ded = 1'b1;
        end
        data = extract_data(fixed);
    end

endmodule

// File: rtl/ecc_fifo_reader.sv
// ECC FIFO reader: pops codewords, corrects them and presents bytes through a
// 2-entry ready/valid output buffer with saturating error statistics.
module ecc_fifo_reader
    import ecc_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [CW_W-1:0]   mem_rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              sec_err,
    output logic              ded_err,
    output logic [7:0]        sec_cnt,
    output logic [7:0]        ded_cnt,
    input  logic              clr_cnt
);

    logic              in_flight_p1;
    logic [DATA_W-1:0] dec_data_p1;
    logic              dec_sec_p1;
    logic              dec_ded_p1;
    rd_entry_t         dec_p1;
    rd_entry_t         head_p2;
    rd_entry_t         tail_p2;
    logic [1:0]        occ_p2;
    logic [1:0]        occ_after_pop;
    logic              pop_out;
    logic [2:0]        fill;
    logic [2:0]        limit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) return v + 8'd1;
        return v;
    endfunction

    // Stage p0 -> p1: pop issue; the codeword returns one cycle later.
    assign pop_out       = dout_valid & dout_ready;
    assign occ_after_pop = occ_p2 - {1'b0, pop_out};
    assign fill          = {1'b0, occ_p2} + {2'b0, in_flight_p1};
    assign limit         = 3'd2 + {2'b0, pop_out};
    assign fifo_rd_en    = rst_n & ~fifo_empty & (fill < limit);

    secded_dec_8 u_dec (
        .cw   (mem_rd_data),
        .data (dec_data_p1),
        .sec  (dec_sec_p1),
        .ded  (dec_ded_p1)
    );

    assign dec_p1 = '{data: dec_data_p1, sec: dec_sec_p1, ded: dec_ded_p1};

    // Stage p1 -> p2: decoded word lands in the first free buffer slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_p1 <= 1'b0;
            occ_p2       <= 2'd0;
            head_p2      <= '0;
        end else begin
            in_flight_p1 <= fifo_rd_en;
            occ_p2       <= occ_after_pop + {1'b0, in_flight_p1};
            if (pop_out && (occ_p2 == 2'd2)) head_p2 <= tail_p2;
            if (in_flight_p1 && (occ_after_pop == 2'd0)) head_p2 <= dec_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight_p1 && (occ_after_pop == 2'd1)) tail_p2 <= dec_p1;
    end

    assign dout       = head_p2.data;
    assign sec_err    = head_p2.sec;
    assign ded_err    = head_p2.ded;
    assign dout_valid = (occ_p2 != 2'd0);

    // Statistics count at capture time, independent of output back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= 8'd0;
            ded_cnt <= 8'd0;
        end else if (clr_cnt) begin
            sec_cnt <= 8'd0;
            ded_cnt <= 8'd0;
        end else begin
            sec_cnt <= sat_inc(sec_cnt, in_flight_p1 & dec_sec_p1);
            ded_cnt <= sat_inc(ded_cnt, in_flight_p1 & dec_ded_p1);
        end
    end

endmodule

// File: tb/tb_ecc_fifo_reader.sv
// Directed bench for ecc_fifo_reader: FIFO/memory model, in-order scoreboard
// and hand-computed codewords for the corrected and uncorrectable cases.
module tb_ecc_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [12:0] mem_rd_data = '0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        sec_err;
    logic        ded_err;
    logic [7:0]  sec_cnt;
    logic [7:0]  ded_cnt;
    logic        clr_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    logic [12:0] fmem [512];
    logic [8:0]  wr_ptr = '0;
    logic [8:0]  rd_ptr = '0;
    exp_t        exp_q [$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int          n_xfer = 0;
    int          outstanding = 0;
    int          viol = 0;
    int          rst_epoch = 0;
    int          seen_epoch = 0;
    int          base;

    always #5 clk = ~clk;

    ecc_fifo_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .mem_rd_data (mem_rd_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .sec_err     (sec_err),
        .ded_err     (ded_err),
        .sec_cnt     (sec_cnt),
        .ded_cnt     (ded_cnt),
        .clr_cnt     (clr_cnt)
    );

    // FIFO controller + raw memory: data appears the cycle after the pop.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            mem_rd_data <= fmem[rd_ptr];
            rd_ptr      <= rd_ptr + 9'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        c     = '0;
        c[3]  = d[0]; c[5]  = d[1]; c[6]  = d[2]; c[7]  = d[3];
        c[9]  = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
        c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
        c[0]  = ^c[12:1];
        return c;
    endfunction

    task automatic push(input logic [12:0] cw, input logic [7:0] d, input logic s, input logic e);
        fmem[wr_ptr] = cw;
        wr_ptr       = wr_ptr + 9'd1;
        exp_q.push_back({d, s, e});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !fifo_empty) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard and pop-gating monitor, sampled just before the rising edge.
    always @(negedge clk) begin
        #2;
        if (seen_epoch != rst_epoch) begin
            seen_epoch  = rst_epoch;
            outstanding = 0;
        end
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (fifo_rd_en && (fifo_empty || (outstanding - int'(dout_valid && dout_ready)) >= 2))
                viol++;
            if (dout_valid && dout_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(dout), 32'h100);
                end else begin
                    cur = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(cur.d));
                    chk("sec_err", 32'(sec_err), 32'(cur.s));
                    chk("ded_err", 32'(ded_err), 32'(cur.e));
                end
            end
            outstanding = outstanding + int'(fifo_rd_en) - int'(dout_valid && dout_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        dout_ready = 1'b1;
        clr_cnt    = 1'b0;
        push(enc(8'h77), 8'h77, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sec", 32'(sec_err), 32'd0);
        chk("rst_ded", 32'(ded_err), 32'd0);
        chk("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("rst_ded_cnt", 32'(ded_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("first_pop", 32'(fifo_rd_en), 32'd1);
        wait_drain();

        // 16 clean bytes: 2-cycle latency, then one byte per cycle.
        base = n_xfer;
        for (int i = 0; i < 16; i++) push(enc(8'(i)), 8'(i), 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 chk("lat_n1_valid", 32'(dout_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        #1 chk("lat_n2_valid", 32'(dout_valid), 32'd1);
        chk("lat_n2_dout", 32'(dout), 32'd0);
        repeat (15) @(negedge clk);
        #3 chk("burst_count", 32'(n_xfer - base), 32'd16);
        wait_drain();
        chk("clean_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("clean_ded_cnt", 32'(ded_cnt), 32'd0);

        // 0xA5 (cw 0x144E) with position 6 flipped.
        push(13'h140E, 8'hA5, 1'b1, 1'b0);
        wait_drain();
        chk("a5_sec_cnt", 32'(sec_cnt), 32'd1);
        // 0x3C (cw 0x06C5) with positions 3 and 10 flipped: raw data 0x1D.
        push(13'h02CD, 8'h1D, 1'b0, 1'b1);
        wait_drain();
        chk("3c_ded_cnt", 32'(ded_cnt), 32'd1);
        chk("3c_sec_cnt", 32'(sec_cnt), 32'd1);
        // 0x5A (cw 0x0AA0) with cw[0] flipped.
        push(13'h0AA1, 8'h5A, 1'b1, 1'b0);
        wait_drain();
        chk("5a_sec_cnt", 32'(sec_cnt), 32'd2);

        // Back-pressure: fill, stall, then toggle ready every cycle.
        base       = n_xfer;
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push(enc(8'h80 + 8'(i)) ^ ((i == 5) ? 13'h1000 : 13'h0), 8'h80 + 8'(i), (i == 5), 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid", 32'(dout_valid), 32'd1);
            chk("stall_dout", 32'(dout), 32'h80);
            chk("stall_rd_en", 32'(fifo_rd_en), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 40; k++) begin
            dout_ready = ~dout_ready;
            @(negedge clk);
        end
        dout_ready = 1'b1;
        wait_drain();
        chk("toggle_count", 32'(n_xfer - base), 32'd8);

        // Saturation and clear priority.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1 chk("clr_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("clr_ded_cnt", 32'(ded_cnt), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 300; i++)
            push(enc(8'(i)) ^ (13'd1 << (i % 13)), 8'(i), 1'b1, 1'b0);
        wait_drain();
        chk("sat_sec_cnt", 32'(sec_cnt), 32'hFF);
        chk("sat_ded_cnt", 32'(ded_cnt), 32'd0);
        push(enc(8'h42) ^ 13'h1, 8'h42, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1 chk("clr_vs_inc", 32'(sec_cnt), 32'd0);
        wait_drain();

        // Reset pulse while w0 is buffered and w1 is returning from memory.
        base = n_xfer;
        for (int i = 0; i < 4; i++)
            push(enc(8'h10 + 8'(i)) ^ 13'h0080, 8'h10 + 8'(i), 1'b1, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid_rst_sec_cnt", 32'(sec_cnt), 32'd0);
        rst_n = 1'b1;
        rst_epoch++;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        wait_drain();
        chk("post_rst_count", 32'(n_xfer - base), 32'd2);
        chk("post_rst_sec_cnt", 32'(sec_cnt), 32'd2);

        chk("rd_gate_viol", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_fifo_reader.md
ECC_FIFO_READER -- requirements
Module: ecc_fifo_reader

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 fifo_empty  input  1  empty flag from FIFO controller.
REQ-004 fifo_rd_en  output  1  pop request to FIFO controller rd_en; a pop occurs in any cycle where fifo_rd_en=1.
REQ-005 mem_rd_data  input  13  codeword from raw memory, valid exactly one cycle after a pop cycle.
REQ-006 dout  output  8  corrected data byte.
REQ-007 dout_valid  output  1  dout holds a valid byte.
REQ-008 dout_ready  input  1  consumer accepts; transfer when dout_valid && dout_ready.
REQ-009 sec_err / ded_err  output  1 each  error flags aligned with the current dout.
REQ-010 sec_cnt / ded_cnt  output  8 each  saturating counts of corrected / uncorrectable words.
REQ-011 clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-012 Codeword format SHALL be: cw[12:1] Hamming positions 1..12, parity bits at positions 1,2,4,8, data d[0..7] at positions 3,5,6,7,9,10,11,12; cw[0] = even overall parity of cw[12:1].
REQ-013 Syndrome s[3:0] SHALL be the XOR of position indices of all set bits in cw[12:1]; p = XOR of all 13 bits.
REQ-014 Decode: s=0,p=0 -> clean; s=0,p=1 -> error in cw[0], data unchanged, sec; s in 1..12,p=1 -> flip position s, sec; s!=0,p=0 -> ded; s in 13..15,p=1 -> ded.
REQ-015 On ded, dout SHALL carry the uncorrected data bits and ded_err=1; sec_err and ded_err SHALL never both be 1.
REQ-016 fifo_rd_en SHALL be asserted only when fifo_empty=0 and (occupancy + in_flight - pop_out) < 2, where occupancy = entries in the 2-deep output buffer, in_flight = pop issued last cycle, pop_out = dout_valid && dout_ready.
REQ-017 Pop at cycle N -> codeword captured and decoded at N+1 -> dout_valid=1 from N+2 (2-cycle latency).
REQ-018 Sustained throughput SHALL be one byte per cycle when FIFO non-empty and dout_ready held 1.
REQ-019 Output order SHALL equal pop order; no byte dropped or duplicated under any dout_ready pattern.
REQ-020 dout, dout_valid, sec_err, ded_err SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-021 Counters SHALL increment once per decoded word (at capture), saturate at 8'hFF, and clr_cnt SHALL take priority over an increment in the same cycle.

Reset
REQ-022 On rst_n=0: fifo_rd_en=0, dout_valid=0, dout=8'h00, sec_err=0, ded_err=0, sec_cnt=0, ded_cnt=0, buffer and in_flight cleared.
REQ-023 A codeword returning after a pop issued before a mid-operation reset SHALL be discarded.
REQ-024 First pop SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-025 Package ecc_fifo_pkg SHALL hold DATA_W=8, CW_W=13, ADDR_W=4 and the data-bit position table.
REQ-026 Combinational decoder SHALL be sub-module secded_dec_8 (cw in; data, sec, ded out), reusable by other readers.

Verification
REQ-027 Write 0x00..0x0F clean, dout_ready=1 -> 16 bytes in order, one per cycle after 2-cycle latency, counters 0.
REQ-028 Codeword of 0xA5 with position 6 flipped -> dout=0xA5, sec_err=1, sec_cnt=1.
REQ-029 Codeword of 0x3C with positions 3 and 10 flipped -> ded_err=1, sec_err=0, ded_cnt=1.
REQ-030 Codeword of 0x5A with cw[0] flipped -> dout=0x5A, sec_err=1.
REQ-031 8 words queued, dout_ready toggled 1/0 each cycle -> all 8 delivered in order, fifo_rd_en never asserted with buffer+in_flight at 2.
REQ-032 300 single-error words -> sec_cnt=8'hFF; clr_cnt coincident with an error -> sec_cnt=0; reset mid-stream -> dout_valid=0 next cycle, in-flight word discarded.
